// File: rtl/tcdm_req_slice.sv
// Request FIFO plus response register that decouples a master from the TCDM arbiter, with a cap on outstanding requests.
// Request latency: m_req 1 cycle after accept into an empty FIFO. Response latency: 1 cycle. s_gnt never looks at s_req or m_gnt.
module tcdm_req_slice #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned MAX_OUTST  = 4,
   localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  s_req,
   input  logic [ADDR_WIDTH-1:0] s_add,
   input  logic                  s_wen,
   input  logic [DATA_WIDTH-1:0] s_wdata,
   input  logic [BE_WIDTH-1:0]   s_be,
   output logic                  s_gnt,
   output logic [DATA_WIDTH-1:0] s_r_rdata,
   output logic                  s_r_valid,
   output logic                  s_r_opc,
   output logic                  m_req,
   output logic [ADDR_WIDTH-1:0] m_add,
   output logic                  m_wen,
   output logic [DATA_WIDTH-1:0] m_wdata,
   output logic [BE_WIDTH-1:0]   m_be,
   input  logic                  m_gnt,
   input  logic [DATA_WIDTH-1:0] m_r_rdata,
   input  logic                  m_r_valid,
   input  logic                  m_r_opc,
   output logic                  busy_o,
   output logic                  err_o
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] add;
      logic                  wen;
      logic [DATA_WIDTH-1:0] wdata;
      logic [BE_WIDTH-1:0]   be;
   } req_t;

   req_t             mem [FIFO_DEPTH];
   req_t             head;
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;
   logic [CNT_W-1:0] cnt;
   logic             empty;
   logic             full;
   logic             push;
   logic             pop;

   // Extra MSB on the pointers distinguishes full from empty.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

   assign s_gnt = !full && (cnt < CNT_MAX) && !rst_i;
   assign push  = s_req && s_gnt;
   assign pop   = m_req && m_gnt;

   assign head    = mem[rd_ptr[PTR_W-1:0]];
   assign m_req   = !empty;
   assign m_add   = head.add;
   assign m_wen   = head.wen;
   assign m_wdata = head.wdata;
   assign m_be    = head.be;

   assign busy_o = !empty || (cnt != '0);

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr[PTR_W-1:0]] <= '{add: s_add, wen: s_wen, wdata: s_wdata, be: s_be};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // A response with no credit outstanding is still forwarded; the counter saturates and the error sticks.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt   <= '0;
         err_o <= 1'b0;
      end else begin
         if (push && !s_r_valid) begin
            cnt <= cnt + 1'b1;
         end else if (!push && s_r_valid && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
         end
         if (s_r_valid && (cnt == '0)) err_o <= 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s_r_valid <= 1'b0;
         s_r_rdata <= '0;
         s_r_opc   <= 1'b0;
      end else begin
         s_r_valid <= m_r_valid;
         if (m_r_valid) begin
            s_r_rdata <= m_r_rdata;
            s_r_opc   <= m_r_opc;
         end
      end
   end

endmodule

// File: tb/tb_tcdm_req_slice.sv
// Bench for tcdm_req_slice: cycle table, directed corner sequences, then random traffic against a queue-based model.
module tb_tcdm_req_slice;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        s_req = 1'b0;
   logic [31:0] s_add = '0;
   logic        s_wen = 1'b0;
   logic [31:0] s_wdata = '0;
   logic [3:0]  s_be = '0;
   logic        s_gnt;
   logic [31:0] s_r_rdata;
   logic        s_r_valid;
   logic        s_r_opc;
   logic        m_req;
   logic [31:0] m_add;
   logic        m_wen;
   logic [31:0] m_wdata;
   logic [3:0]  m_be;
   logic        m_gnt = 1'b0;
   logic [31:0] m_r_rdata = '0;
   logic        m_r_valid = 1'b0;
   logic        m_r_opc = 1'b0;
   logic        busy_o;
   logic        err_o;

   tcdm_req_slice #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(2), .MAX_OUTST(4)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .s_req(s_req), .s_add(s_add), .s_wen(s_wen), .s_wdata(s_wdata), .s_be(s_be),
      .s_gnt(s_gnt), .s_r_rdata(s_r_rdata), .s_r_valid(s_r_valid), .s_r_opc(s_r_opc),
      .m_req(m_req), .m_add(m_add), .m_wen(m_wen), .m_wdata(m_wdata), .m_be(m_be),
      .m_gnt(m_gnt), .m_r_rdata(m_r_rdata), .m_r_valid(m_r_valid), .m_r_opc(m_r_opc),
      .busy_o(busy_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
      end
   endtask

   task automatic idle();
      s_req = 1'b0; s_add = '0; s_wen = 1'b0; s_wdata = '0; s_be = '0;
      m_gnt = 1'b0; m_r_valid = 1'b0; m_r_rdata = '0; m_r_opc = 1'b0;
   endtask

   // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
   task automatic cyc();
      @(posedge clk_i);
      #2;
      idle();
   endtask

   typedef struct packed {
      logic [31:0] add;
      logic        wen;
      logic [31:0] wdata;
      logic [3:0]  be;
   } mreq_t;

   mreq_t       q[$];
   int          m_cnt;
   bit          m_srv;
   logic [31:0] m_srd;
   bit          m_sopc;
   bit          m_err;
   int          ds_pend;

   function automatic void model_reset();
      q.delete();
      m_cnt = 0; m_srv = 0; m_srd = '0; m_sopc = 0; m_err = 0; ds_pend = 0;
   endfunction

   task automatic do_reset();
      cyc();
      rst_i = 1'b1;
      #1;
      chk("rst_m_req", 64'(m_req), 64'(0));
      chk("rst_s_gnt", 64'(s_gnt), 64'(0));
      chk("rst_busy", 64'(busy_o), 64'(0));
      chk("rst_err", 64'(err_o), 64'(0));
      chk("rst_s_r_valid", 64'(s_r_valid), 64'(0));
      chk("rst_s_r_rdata", 64'(s_r_rdata), 64'(0));
      chk("rst_s_r_opc", 64'(s_r_opc), 64'(0));
      cyc();
      rst_i = 1'b0;
      #1;
      chk("post_rst_gnt", 64'(s_gnt), 64'(1));
      model_reset();
   endtask

   typedef struct {
      logic        req;
      logic [31:0] add;
      logic        mgnt;
      logic        mrv;
      logic [31:0] mrd;
      logic        e_gnt;
      logic        e_mreq;
      logic [31:0] e_madd;
      logic        e_srv;
      logic [31:0] e_srd;
      logic        e_busy;
   } vec_t;

   vec_t tbl[17];

   initial begin
      int grants;

      tbl[0]  = '{1'b1, 32'h1000_0004, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0};
      tbl[1]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h1000_0004, 1'b0, 32'h0,         1'b1};
      tbl[2]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1};
      tbl[3]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b1};
      tbl[4]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0};
      tbl[5]  = '{1'b1, 32'h2000_0000, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0};
      tbl[6]  = '{1'b1, 32'h2000_0010, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h2000_0000, 1'b0, 32'h0,         1'b1};
      tbl[7]  = '{1'b1, 32'h2000_0020, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h2000_0000, 1'b0, 32'h0,         1'b1};
      tbl[8]  = '{1'b1, 32'h2000_0020, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h2000_0000, 1'b0, 32'h0,         1'b1};
      tbl[9]  = '{1'b1, 32'h2000_0020, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h2000_0010, 1'b0, 32'h0,         1'b1};
      tbl[10] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h2000_0010, 1'b0, 32'h0,         1'b1};
      tbl[11] = '{1'b1, 32'h2000_0030, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h2000_0020, 1'b0, 32'h0,         1'b1};
      tbl[12] = '{1'b1, 32'h2000_0040, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h2000_0030, 1'b0, 32'h0,         1'b1};
      tbl[13] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h1111_0000, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1};
      tbl[14] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h2222_0001, 1'b0, 1'b0, 32'h0,         1'b1, 32'h1111_0000, 1'b1};
      tbl[15] = '{1'b1, 32'h2000_0050, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h2222_0001, 1'b1};
      tbl[16] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h2000_0050, 1'b0, 32'h0,         1'b1};

      idle();
      repeat (2) @(posedge clk_i);
      do_reset();

      // Single read, FIFO full with a pop, credit exhaustion, push coinciding with a response.
      for (int i = 0; i < 17; i++) begin
         cyc();
         s_req = tbl[i].req; s_add = tbl[i].add; s_wen = (i == 0);
         s_wdata = tbl[i].add ^ 32'h5A5A_5A5A; s_be = 4'hF;
         m_gnt = tbl[i].mgnt; m_r_valid = tbl[i].mrv; m_r_rdata = tbl[i].mrd;
         #1;
         chk($sformatf("tbl%0d_gnt", i), 64'(s_gnt), 64'(tbl[i].e_gnt));
         chk($sformatf("tbl%0d_mreq", i), 64'(m_req), 64'(tbl[i].e_mreq));
         if (tbl[i].e_mreq) chk($sformatf("tbl%0d_madd", i), 64'(m_add), 64'(tbl[i].e_madd));
         chk($sformatf("tbl%0d_srv", i), 64'(s_r_valid), 64'(tbl[i].e_srv));
         if (tbl[i].e_srv) chk($sformatf("tbl%0d_srd", i), 64'(s_r_rdata), 64'(tbl[i].e_srd));
         chk($sformatf("tbl%0d_busy", i), 64'(busy_o), 64'(tbl[i].e_busy));
      end

      // Credit limit with m_gnt held high and no responses.
      do_reset();
      grants = 0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         s_req = 1'b1; s_add = 32'h3000_0000 + 32'(i); m_gnt = 1'b1;
         #1;
         if (s_gnt) grants++;
      end
      chk("credit_grants", 64'(grants), 64'(4));
      cyc();
      m_r_valid = 1'b1; m_r_rdata = 32'h0BAD_CAFE;
      #1;
      chk("credit_gnt_blocked", 64'(s_gnt), 64'(0));
      cyc();
      #1;
      chk("credit_srv", 64'(s_r_valid), 64'(1));
      chk("credit_gnt_still0", 64'(s_gnt), 64'(0));
      cyc();
      #1;
      chk("credit_gnt_back", 64'(s_gnt), 64'(1));

      // Underflow: response with no credit outstanding.
      do_reset();
      cyc();
      m_r_valid = 1'b1; m_r_rdata = 32'hCAFE_F00D; m_r_opc = 1'b1;
      #1;
      chk("uf_err_pre", 64'(err_o), 64'(0));
      cyc();
      #1;
      chk("uf_srv", 64'(s_r_valid), 64'(1));
      chk("uf_srd", 64'(s_r_rdata), 64'(32'hCAFE_F00D));
      chk("uf_opc", 64'(s_r_opc), 64'(1));
      cyc();
      #1;
      chk("uf_err", 64'(err_o), 64'(1));
      chk("uf_busy", 64'(busy_o), 64'(0));
      chk("uf_gnt", 64'(s_gnt), 64'(1));
      chk("uf_srd_hold", 64'(s_r_rdata), 64'(32'hCAFE_F00D));
      repeat (3) cyc();
      #1;
      chk("uf_err_sticky", 64'(err_o), 64'(1));

      // Reset mid-operation with two queued entries and three credits in use.
      cyc(); s_req = 1'b1; s_add = 32'h4000_0000;
      cyc(); m_gnt = 1'b1;
      cyc(); s_req = 1'b1; s_add = 32'h4000_0010;
      cyc(); s_req = 1'b1; s_add = 32'h4000_0020;
      cyc();
      #1;
      chk("mid_mreq_pre", 64'(m_req), 64'(1));
      chk("mid_madd_pre", 64'(m_add), 64'(32'h4000_0010));
      chk("mid_gnt_full", 64'(s_gnt), 64'(0));
      #1;
      rst_i = 1'b1;
      #1;
      chk("mid_rst_mreq", 64'(m_req), 64'(0));
      chk("mid_rst_gnt", 64'(s_gnt), 64'(0));
      chk("mid_rst_busy", 64'(busy_o), 64'(0));
      chk("mid_rst_err", 64'(err_o), 64'(0));
      cyc();
      rst_i = 1'b0;
      #1;
      chk("mid_rel_gnt", 64'(s_gnt), 64'(1));
      for (int i = 0; i < 3; i++) begin
         cyc();
         #1;
         chk($sformatf("mid_no_replay%0d", i), 64'(m_req), 64'(0));
         chk($sformatf("mid_idle_busy%0d", i), 64'(busy_o), 64'(0));
      end

      // Random traffic with an in-order downstream responder.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         bit e_gnt, push, pop;
         cyc();
         s_req = ($urandom_range(0, 3) != 0);
         s_add = $urandom; s_wen = 1'($urandom); s_wdata = $urandom; s_be = 4'($urandom);
         m_gnt = ($urandom_range(0, 2) != 0);
         m_r_valid = (ds_pend > 0) && ($urandom_range(0, 3) == 0 || c % 50 > 25);
         m_r_rdata = $urandom; m_r_opc = 1'($urandom);
         #1;
         e_gnt = (q.size() < 2) && (m_cnt < 4);
         chk("rnd_gnt", 64'(s_gnt), 64'(e_gnt));
         chk("rnd_mreq", 64'(m_req), 64'(q.size() > 0));
         if (q.size() > 0) begin
            chk("rnd_madd", 64'(m_add), 64'(q[0].add));
            chk("rnd_mwen", 64'(m_wen), 64'(q[0].wen));
            chk("rnd_mwdata", 64'(m_wdata), 64'(q[0].wdata));
            chk("rnd_mbe", 64'(m_be), 64'(q[0].be));
         end
         chk("rnd_srv", 64'(s_r_valid), 64'(m_srv));
         chk("rnd_srd", 64'(s_r_rdata), 64'(m_srd));
         chk("rnd_sopc", 64'(s_r_opc), 64'(m_sopc));
         chk("rnd_busy", 64'(busy_o), 64'((q.size() > 0) || (m_cnt != 0)));
         chk("rnd_err", 64'(err_o), 64'(m_err));

         push = s_req && e_gnt;
         pop  = (q.size() > 0) && m_gnt;
         if (m_r_valid) ds_pend--;
         if (pop) begin
            void'(q.pop_front());
            ds_pend++;
         end
         if (push) q.push_back('{add: s_add, wen: s_wen, wdata: s_wdata, be: s_be});
         if (m_srv && m_cnt == 0) m_err = 1;
         if (push && !m_srv) m_cnt++;
         else if (!push && m_srv && m_cnt > 0) m_cnt--;
         m_srv = m_r_valid;
         if (m_r_valid) begin
            m_srd = m_r_rdata;
            m_sopc = m_r_opc;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
